// File: rtl/spi_master_fifo.sv
// First-word-fall-through FIFO with occupancy count and an upward threshold-crossing pulse.
// Used as both the TX and RX buffer of the SPI master.
module spi_master_fifo #(
  parameter int DATA_WIDTH       = 32,
  parameter int BUFFER_DEPTH     = 32,
  parameter int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic                        clr_i,
  input  logic [DATA_WIDTH-1:0]       data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [LOG_BUFFER_DEPTH:0]   elements_o,
  output logic                        full_o,
  output logic                        empty_o,
  input  logic [LOG_BUFFER_DEPTH:0]   th_i,
  output logic                        th_event_o
);

  localparam logic [LOG_BUFFER_DEPTH:0]   FULL_COUNT = (LOG_BUFFER_DEPTH+1)'(BUFFER_DEPTH);
  localparam logic [LOG_BUFFER_DEPTH:0]   CNT_ONE    = (LOG_BUFFER_DEPTH+1)'(1);
  localparam logic [LOG_BUFFER_DEPTH-1:0] PTR_ONE    = LOG_BUFFER_DEPTH'(1);

  logic [DATA_WIDTH-1:0]       mem [BUFFER_DEPTH];
  logic [LOG_BUFFER_DEPTH-1:0] wr_ptr;
  logic [LOG_BUFFER_DEPTH-1:0] rd_ptr;
  logic [LOG_BUFFER_DEPTH:0]   count_next;
  logic                        above_q;
  logic                        above_next;
  logic                        push;
  logic                        pop;

  assign full_o  = (elements_o == FULL_COUNT);
  assign empty_o = (elements_o == '0);
  assign ready_o = ~full_o;
  assign valid_o = ~empty_o;
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;
  assign data_o  = mem[rd_ptr];

  always_comb begin
    count_next = elements_o;
    if (clr_i)
      count_next = '0;
    else if (push && !pop)
      count_next = elements_o + CNT_ONE;
    else if (pop && !push)
      count_next = elements_o - CNT_ONE;
  end

  // A zero threshold never counts as "above", which disables the event.
  assign above_next = (count_next >= th_i) && (th_i != '0);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      elements_o <= '0;
      above_q    <= 1'b0;
      th_event_o <= 1'b0;
    end else begin
      elements_o <= count_next;
      above_q    <= above_next;
      th_event_o <= above_next & ~above_q & ~clr_i;
      if (clr_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage is never reset or flushed; only the pointers define validity.
  always_ff @(posedge HCLK) begin
    if (push && !clr_i)
      mem[wr_ptr] <= data_i;
  end

endmodule

// File: doc/spi_master_fifo.md
# spi_master_fifo

Synchronous first-word-fall-through FIFO with an occupancy-threshold event, used twice in the SPI master. The TX instance sits between the APB register interface (spi_data_tx / spi_data_tx_valid / spi_data_tx_ready) and the SPI shift engine. The RX instance sits between the shift engine and the APB interface (spi_data_rx / spi_data_rx_valid / spi_data_rx_ready). Occupancy counts feed the spi_status word, and threshold events feed the interrupt logic.

## Interface
- DATA_WIDTH, 32, width of one FIFO word.
- BUFFER_DEPTH, 32, number of entries; power of two, ≥2.
- LOG_BUFFER_DEPTH, $clog2(BUFFER_DEPTH), pointer width; occupancy width is LOG_BUFFER_DEPTH+1.
- HCLK  in  1  clock; all state updates on rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- clr_i  in  1  synchronous flush; wired to spi_swrst.
- data_i  in  DATA_WIDTH  write data.
- valid_i  in  1  write request.
- ready_o  out  1  space available (= ~full_o).
- data_o  out  DATA_WIDTH  head-of-FIFO data.
- valid_o  out  1  data available (= ~empty_o).
- ready_i  in  1  consumer accepts head word.
- elements_o  out  LOG_BUFFER_DEPTH+1  current occupancy, 0..BUFFER_DEPTH.
- full_o  out  1  elements_o == BUFFER_DEPTH.
- empty_o  out  1  elements_o == 0.
- th_i  in  LOG_BUFFER_DEPTH+1  event threshold; 0 disables the event.
- th_event_o  out  1  one-cycle pulse on an upward threshold crossing.

## Operation
- Storage is a circular buffer mem[BUFFER_DEPTH] with wr_ptr and rd_ptr, each LOG_BUFFER_DEPTH bits, wrapping naturally from BUFFER_DEPTH-1 to 0. There is a separate count register, elements_o.
- Push happens when valid_i & ready_o: mem[wr_ptr] <= data_i and wr_ptr++.
- Pop happens when valid_o & ready_i: rd_ptr++.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- data_o = mem[rd_ptr], a combinational read. data_o is don't-care while valid_o=0.
- Full: ready_o=0 and valid_i is ignored, even if a pop occurs in the same cycle. There is no write-through on full.
- Empty: valid_o=0 and ready_i is ignored. A push into an empty FIFO is not bypassed; the word appears on data_o the next cycle.
- clr_i=1 at a clock edge:
  - wr_ptr, rd_ptr and count go to 0, and th_event_o goes to 0.
  - clr_i overrides any push or pop in the same cycle.
  - mem contents are not cleared.
- Threshold event:
  - A registered flag above_q = (elements_o >= th_i) && (th_i != 0).
  - th_event_o = above_next & ~above_q, registered, where above_next is computed from the next-cycle count.
  - The pulse therefore lasts exactly one cycle, aligned with the cycle in which elements_o first shows a value ≥ th_i.
  - There is no new pulse until the count falls below th_i and crosses it again.
  - Changing th_i downward past the current count also produces one pulse.
- No state machine beyond the pointers, count and above_q. No error outputs; overflow and underflow are impossible by construction.

## Timing
- Reset (HRESETn=0, async) sets:
  - wr_ptr=0, rd_ptr=0, elements_o=0
  - full_o=0, empty_o=1, ready_o=1, valid_o=0
  - th_event_o=0, above_q=0
- Outputs are stable from reset assertion. Reset deassertion is synchronous to HCLK on the implementation side.
- Write-to-read latency: a word pushed at edge N is on data_o with valid_o=1 after edge N.
- Throughput is one push and one pop per cycle, sustained, at any occupancy other than full (push blocked) or empty (pop blocked).
- elements_o, full_o and empty_o are all derived from registers. ready_o and valid_o have no combinational path from valid_i or ready_i.
- Reset mid-operation discards all contents. The first push after reset lands in mem[0].

## Test plan
- Reset, then idle for 3 cycles: elements_o=0, empty_o=1, ready_o=1, valid_o=0, th_event_o=0.
- Push 32 words 0x1000+i back-to-back with ready_i=0: after the 32nd edge full_o=1, ready_o=0, elements_o=32. A 33rd push (0xDEAD) is dropped. Then drain with ready_i=1: exactly 0x1000..0x101F in order, after which empty_o=1.
- Steady state at elements_o=5, with valid_i=ready_i=1 for 100 cycles and incrementing data: elements_o stays 5 and the output sequence matches the input delayed by 5 pops. This exercises pointer wrap at least 3 times.
- Full FIFO with valid_i=1 and ready_i=1 in the same cycle: the pop is accepted, the push is dropped, elements_o becomes 31 and ready_o=1 on the next cycle.
- th_i=4, pushing singly:
  - th_event_o pulses exactly once, in the cycle elements_o becomes 4, and stays 0 at 5..8.
  - Pop down to 3, then push: a second single pulse.
  - With th_i=0: no pulses at any count.
- At elements_o=10, assert clr_i for one cycle together with valid_i=1: the next cycle shows elements_o=0, empty_o=1, valid_o=0. The next push 0xA5A5A5A5 appears on data_o one cycle later.
